// File: rtl/stage3_message_serializer_pkg.sv
// Shared constants, size/count codes and FSM state type for the stage3 message serializer.
// Slot helpers pick the next non-empty slot from a three-bit occupancy mask.
package stage3_message_serializer_pkg;

   localparam int unsigned DEF_DATA_BYTES    = 8;
   localparam int unsigned DEF_MSG_MAX_BYTES = 35;
   localparam int unsigned DEF_SIZE_WIDTH    = 6;
   localparam int unsigned DEF_SEQ_WIDTH     = 32;

   localparam logic [5:0] BLOCK_SIZE_EMPTY = 6'd0;
   localparam logic [5:0] BLOCK_SIZE_35    = 6'd35;
   localparam logic [5:0] BLOCK_SIZE_22    = 6'd22;
   localparam logic [5:0] BLOCK_SIZE_21    = 6'd21;
   localparam logic [5:0] BLOCK_SIZE_12    = 6'd12;

   localparam logic [1:0] MESSAGE_NUMBER_DATA_0 = 2'd0;
   localparam logic [1:0] MESSAGE_NUMBER_DATA_1 = 2'd1;
   localparam logic [1:0] MESSAGE_NUMBER_DATA_2 = 2'd2;
   localparam logic [1:0] MESSAGE_NUMBER_DATA_3 = 2'd3;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   function automatic logic [1:0] first_slot(input logic [2:0] nz);
      if (nz[0])      return 2'd0;
      else if (nz[1]) return 2'd1;
      else            return 2'd2;
   endfunction

   function automatic logic [2:0] slots_after(input logic [1:0] slot);
      case (slot)
         2'd0:    return 3'b110;
         2'd1:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [1:0] count_slots(input logic [2:0] nz);
      return 2'(nz[0]) + 2'(nz[1]) + 2'(nz[2]);
   endfunction

endpackage

// File: rtl/stage3_message_serializer_beat_slicer.sv
// Combinational slicer: selects beat `beat` of a message of `size` bytes, LSB-aligned,
// with bytes beyond the message end masked to zero.
module stage3_beat_slicer #(
   parameter int unsigned DATA_BYTES    = 8,
   parameter int unsigned MSG_MAX_BYTES = 35,
   parameter int unsigned SIZE_WIDTH    = 6,
   parameter int unsigned BEAT_WIDTH    = 3
) (
   input  logic [8*MSG_MAX_BYTES-1:0] payload,
   input  logic [SIZE_WIDTH-1:0]      size,
   input  logic [BEAT_WIDTH-1:0]      beat,
   output logic [8*DATA_BYTES-1:0]    data,
   output logic [DATA_BYTES-1:0]      keep,
   output logic                       last
);

   logic [SIZE_WIDTH-1:0]      base;
   logic [SIZE_WIDTH-1:0]      remaining;
   logic [8*MSG_MAX_BYTES-1:0] shifted;

   always_comb begin
      base      = SIZE_WIDTH'(beat) * SIZE_WIDTH'(DATA_BYTES);
      remaining = size - base;
      last      = (remaining <= SIZE_WIDTH'(DATA_BYTES));
      shifted   = payload >> (32'(beat) * 32'(8 * DATA_BYTES));
      keep      = '0;
      data      = '0;
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
         keep[i]        = (SIZE_WIDTH'(i) < remaining);
         data[8*i +: 8] = keep[i] ? shifted[8*i +: 8] : 8'h00;
      end
   end

endmodule

// File: rtl/stage3_message_serializer.sv
// Serialises a group of up to three messages in slot order onto a valid/ready beat stream,
// skipping empty slots and stamping each message with a running sequence number.
module stage3_message_serializer
   import stage3_message_serializer_pkg::*;
#(
   parameter int unsigned          DATA_BYTES      = DEF_DATA_BYTES,
   parameter int unsigned          MSG_MAX_BYTES   = DEF_MSG_MAX_BYTES,
   parameter int unsigned          SIZE_WIDTH      = DEF_SIZE_WIDTH,
   parameter int unsigned          SEQ_WIDTH       = DEF_SEQ_WIDTH,
   parameter logic [SEQ_WIDTH-1:0] SEQ_RESET_VALUE = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [8*MSG_MAX_BYTES-1:0] m1_payload,
   input  logic [8*MSG_MAX_BYTES-1:0] m2_payload,
   input  logic [8*MSG_MAX_BYTES-1:0] m3_payload,
   input  logic [SIZE_WIDTH-1:0]      block_size_control_m1,
   input  logic [SIZE_WIDTH-1:0]      block_size_control_m2,
   input  logic [SIZE_WIDTH-1:0]      block_size_control_m3,
   input  logic [1:0]                 message_number_control,
   input  logic                       seq_number_control,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [8*DATA_BYTES-1:0]    out_data,
   output logic [DATA_BYTES-1:0]      out_keep,
   output logic                       out_sop,
   output logic                       out_eop,
   output logic                       out_seq_valid,
   output logic [SEQ_WIDTH-1:0]       out_seq_num,
   output logic                       err_count_mismatch
);

   localparam int unsigned PAYLOAD_WIDTH = 8 * MSG_MAX_BYTES;
   localparam int unsigned BEAT_WIDTH    = $clog2((MSG_MAX_BYTES + DATA_BYTES - 1) / DATA_BYTES);

   state_t                   state;
   logic [1:0]               slot_q;
   logic [BEAT_WIDTH-1:0]    beat_q;
   logic [PAYLOAD_WIDTH-1:0] pay_q [3];
   logic [SIZE_WIDTH-1:0]    sz_q  [3];
   logic                     seq_en_q;
   logic [SEQ_WIDTH-1:0]     seq_cnt;

   logic [PAYLOAD_WIDTH-1:0] pay_in [3];
   logic [SIZE_WIDTH-1:0]    sz_in  [3];
   logic [2:0]               nz_in, nz_q, nz_after;
   logic [1:0]               first_in, next_slot;
   logic                     accept;

   logic [PAYLOAD_WIDTH-1:0] sl_pay;
   logic [SIZE_WIDTH-1:0]    sl_size;
   logic [BEAT_WIDTH-1:0]    sl_beat;
   logic [8*DATA_BYTES-1:0]  sl_data;
   logic [DATA_BYTES-1:0]    sl_keep;
   logic                     sl_last;

   function automatic logic [SIZE_WIDTH-1:0] clamp_size(input logic [SIZE_WIDTH-1:0] s);
      return (s > SIZE_WIDTH'(MSG_MAX_BYTES)) ? SIZE_WIDTH'(MSG_MAX_BYTES) : s;
   endfunction

   // The slicer always computes the beat to be registered next: the first beat of the
   // first occupied input slot while idle, otherwise the following beat or next message.
   always_comb begin
      pay_in[0] = m1_payload;
      pay_in[1] = m2_payload;
      pay_in[2] = m3_payload;
      sz_in[0]  = clamp_size(block_size_control_m1);
      sz_in[1]  = clamp_size(block_size_control_m2);
      sz_in[2]  = clamp_size(block_size_control_m3);
      for (int unsigned i = 0; i < 3; i++) begin
         nz_in[i] = |sz_in[i];
         nz_q[i]  = |sz_q[i];
      end
      nz_after  = nz_q & slots_after(slot_q);
      first_in  = first_slot(nz_in);
      next_slot = first_slot(nz_after);
      accept    = in_valid && in_ready;

      sl_pay  = pay_in[first_in];
      sl_size = sz_in[first_in];
      sl_beat = '0;
      if (state == SEND) begin
         if (!out_eop) begin
            sl_pay  = pay_q[slot_q];
            sl_size = sz_q[slot_q];
            sl_beat = beat_q + BEAT_WIDTH'(1);
         end else begin
            sl_pay  = pay_q[next_slot];
            sl_size = sz_q[next_slot];
         end
      end
   end

   stage3_beat_slicer #(
      .DATA_BYTES    (DATA_BYTES),
      .MSG_MAX_BYTES (MSG_MAX_BYTES),
      .SIZE_WIDTH    (SIZE_WIDTH),
      .BEAT_WIDTH    (BEAT_WIDTH)
   ) u_slicer (
      .payload (sl_pay),
      .size    (sl_size),
      .beat    (sl_beat),
      .data    (sl_data),
      .keep    (sl_keep),
      .last    (sl_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         slot_q             <= '0;
         beat_q             <= '0;
         for (int unsigned i = 0; i < 3; i++) begin
            pay_q[i] <= '0;
            sz_q[i]  <= '0;
         end
         seq_en_q           <= 1'b0;
         seq_cnt            <= SEQ_RESET_VALUE;
         in_ready           <= 1'b0;
         out_valid          <= 1'b0;
         out_data           <= '0;
         out_keep           <= '0;
         out_sop            <= 1'b0;
         out_eop            <= 1'b0;
         out_seq_valid      <= 1'b0;
         out_seq_num        <= '0;
         err_count_mismatch <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  pay_q    <= pay_in;
                  sz_q     <= sz_in;
                  seq_en_q <= seq_number_control;
                  if (message_number_control != count_slots(nz_in))
                     err_count_mismatch <= 1'b1;
                  if (|nz_in) begin
                     state         <= SEND;
                     in_ready      <= 1'b0;
                     slot_q        <= first_in;
                     beat_q        <= '0;
                     out_valid     <= 1'b1;
                     out_data      <= sl_data;
                     out_keep      <= sl_keep;
                     out_sop       <= 1'b1;
                     out_eop       <= sl_last;
                     out_seq_valid <= seq_number_control;
                     out_seq_num   <= seq_number_control ? seq_cnt : '0;
                  end
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (!out_eop) begin
                     beat_q   <= sl_beat;
                     out_data <= sl_data;
                     out_keep <= sl_keep;
                     out_sop  <= 1'b0;
                     out_eop  <= sl_last;
                  end else begin
                     if (seq_en_q)
                        seq_cnt <= seq_cnt + SEQ_WIDTH'(1);
                     if (|nz_after) begin
                        slot_q        <= next_slot;
                        beat_q        <= '0;
                        out_data      <= sl_data;
                        out_keep      <= sl_keep;
                        out_sop       <= 1'b1;
                        out_eop       <= sl_last;
                        out_seq_valid <= seq_en_q;
                        out_seq_num   <= seq_en_q ? seq_cnt + SEQ_WIDTH'(1) : '0;
                     end else begin
                        state         <= IDLE;
                        in_ready      <= 1'b1;
                        out_valid     <= 1'b0;
                        out_data      <= '0;
                        out_keep      <= '0;
                        out_sop       <= 1'b0;
                        out_eop       <= 1'b0;
                        out_seq_valid <= 1'b0;
                        out_seq_num   <= '0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage3_message_serializer.sv
// Scoreboard bench for stage3_message_serializer: stimulus pushes expected beats, a negedge
// monitor pops and compares every accepted beat. A second instance starts its counter at 2^32-1.
module tb_stage3_message_serializer;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        sop;
      logic        eop;
      logic        sv;
      logic [31:0] seq;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, in_ready2;
   logic [279:0] m1_payload, m2_payload, m3_payload;
   logic [5:0]   sz1, sz2, sz3;
   logic [1:0]   msg_cnt;
   logic         seq_ctl;
   logic         out_valid, out_ready, out_sop, out_eop, out_seq_valid, err;
   logic [63:0]  out_data;
   logic [7:0]   out_keep;
   logic [31:0]  out_seq_num;
   logic         out_valid2, out_sop2, out_eop2, out_seq_valid2, err2;
   logic [63:0]  out_data2;
   logic [7:0]   out_keep2;
   logic [31:0]  out_seq_num2;

   beat_t        exp_q[$];
   int           eop_pos_q[$];
   logic [7:0]   eop_keep_q[$];
   logic [31:0]  eop_seq_q[$];
   logic [31:0]  seq2_q[$];
   int           beat_cnt;
   logic [31:0]  model_seq;
   int           checks = 0;
   int           errors = 0;
   logic         prev_stall;
   logic [63:0]  held_data;
   logic [7:0]   held_keep;

   always #5 clk = ~clk;

   stage3_message_serializer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .m1_payload(m1_payload), .m2_payload(m2_payload), .m3_payload(m3_payload),
      .block_size_control_m1(sz1), .block_size_control_m2(sz2), .block_size_control_m3(sz3),
      .message_number_control(msg_cnt), .seq_number_control(seq_ctl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
      .out_sop(out_sop), .out_eop(out_eop), .out_seq_valid(out_seq_valid),
      .out_seq_num(out_seq_num), .err_count_mismatch(err)
   );

   stage3_message_serializer #(.SEQ_RESET_VALUE(32'hFFFF_FFFF)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .m1_payload(m1_payload), .m2_payload(m2_payload), .m3_payload(m3_payload),
      .block_size_control_m1(sz1), .block_size_control_m2(sz2), .block_size_control_m3(sz3),
      .message_number_control(msg_cnt), .seq_number_control(seq_ctl),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_keep(out_keep2),
      .out_sop(out_sop2), .out_eop(out_eop2), .out_seq_valid(out_seq_valid2),
      .out_seq_num(out_seq_num2), .err_count_mismatch(err2)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   function automatic logic [279:0] mk_pay(input int slot, input int salt);
      logic [279:0] p = '0;
      for (int k = 0; k < 35; k++) p[8*k +: 8] = 8'(slot * 64 + k + salt);
      return p;
   endfunction

   task automatic push_msg(input logic [279:0] pay, input int size, input logic seq_en);
      int s;
      int beats;
      beat_t e;
      s = (size > 35) ? 35 : size;
      if (s == 0) return;
      beats = (s + 7) / 8;
      for (int b = 0; b < beats; b++) begin
         e = '0;
         for (int i = 0; i < 8; i++) begin
            if (8*b + i < s) begin
               e.data[8*i +: 8] = pay[8*(8*b + i) +: 8];
               e.keep[i]        = 1'b1;
            end
         end
         e.sop = (b == 0);
         e.eop = (b == beats - 1);
         e.sv  = seq_en;
         e.seq = seq_en ? model_seq : 32'd0;
         exp_q.push_back(e);
      end
      if (seq_en) model_seq++;
   endtask

   task automatic send_group(input int s1, input int s2, input int s3, input logic [1:0] cnt,
                             input logic seq, input int salt);
      int n = 0;
      while (!in_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_wait", 64'(in_ready), 64'd1);
      m1_payload = mk_pay(1, salt);
      m2_payload = mk_pay(2, salt);
      m3_payload = mk_pay(3, salt);
      sz1 = 6'(s1); sz2 = 6'(s2); sz3 = 6'(s3);
      msg_cnt = cnt; seq_ctl = seq; in_valid = 1'b1;
      push_msg(m1_payload, s1, seq);
      push_msg(m2_payload, s2, seq);
      push_msg(m3_payload, s3, seq);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid || !in_ready) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
      chk({nm, "_idle"}, 64'({out_valid, in_ready}), 64'b01);
   endtask

   task automatic clear_rec();
      beat_cnt = 0;
      eop_pos_q.delete();
      eop_keep_q.delete();
      eop_seq_q.delete();
   endtask

   task automatic chk_eop(input string nm, input int idx, input int pos, input logic [7:0] keep,
                          input logic [31:0] seq);
      chk({nm, "_eop_pos"}, 64'(eop_pos_q[idx]), 64'(pos));
      chk({nm, "_eop_keep"}, 64'(eop_keep_q[idx]), 64'(keep));
      chk({nm, "_eop_seq"}, 64'(eop_seq_q[idx]), 64'(seq));
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_data"}, out_data, 64'd0);
      chk({nm, "_ctl"}, 64'({out_valid, out_keep, out_sop, out_eop, out_seq_valid, err, in_ready}),
          64'd0);
      chk({nm, "_seq"}, 64'(out_seq_num), 64'd0);
   endtask

   // Monitor: compares every accepted beat against the scoreboard and checks stall stability.
   initial begin : monitor
      beat_t e;
      prev_stall = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
            continue;
         end
         if (out_valid && prev_stall) begin
            chk("stall_data", out_data, held_data);
            chk("stall_keep", 64'(out_keep), 64'(held_keep));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat got data=%h keep=%h exp none", out_data, out_keep);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", out_data, e.data);
               chk("beat_keep", 64'(out_keep), 64'(e.keep));
               chk("beat_flags", 64'({out_sop, out_eop, out_seq_valid}), 64'({e.sop, e.eop, e.sv}));
               chk("beat_seq", 64'(out_seq_num), 64'(e.seq));
               chk("in_ready_busy", 64'(in_ready), 64'd0);
            end
            beat_cnt++;
            if (out_eop) begin
               eop_pos_q.push_back(beat_cnt);
               eop_keep_q.push_back(out_keep);
               eop_seq_q.push_back(out_seq_num);
            end
         end
         prev_stall = out_valid && !out_ready;
         held_data  = out_data;
         held_keep  = out_keep;
      end
   end

   always @(negedge clk)
      if (rst_n && out_valid2 && out_ready && out_eop2) seq2_q.push_back(out_seq_num2);

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin : stimulus
      int pat [8];
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      m1_payload = '0; m2_payload = '0; m3_payload = '0;
      sz1 = '0; sz2 = '0; sz3 = '0; msg_cnt = '0; seq_ctl = 1'b0;
      model_seq = '0;
      clear_rec();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_reset", 64'(in_ready), 64'd1);

      // 1: three messages, stamped, continuous ready
      clear_rec();
      send_group(35, 22, 12, 2'd3, 1'b1, 0);
      wait_idle("t1");
      chk("t1_beats", 64'(beat_cnt), 64'd10);
      chk("t1_msgs", 64'(eop_pos_q.size()), 64'd3);
      chk_eop("t1m1", 0, 5, 8'h07, 32'd0);
      chk_eop("t1m2", 1, 8, 8'h3F, 32'd1);
      chk_eop("t1m3", 2, 10, 8'h0F, 32'd2);

      // 2: only slot 2, unstamped
      clear_rec();
      send_group(0, 21, 0, 2'd1, 1'b0, 5);
      wait_idle("t2");
      chk("t2_beats", 64'(beat_cnt), 64'd3);
      chk_eop("t2", 0, 3, 8'h1F, 32'd0);

      // 3: stalls during a 5-beat message; counter must have stayed at 3
      clear_rec();
      send_group(35, 0, 0, 2'd1, 1'b1, 9);
      pat = '{1, 0, 0, 1, 0, 1, 1, 1};
      for (int i = 0; i < 8; i++) begin
         out_ready = pat[i][0];
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_idle("t3");
      chk("t3_beats", 64'(beat_cnt), 64'd5);
      chk_eop("t3", 0, 5, 8'h07, 32'd3);

      // 4: empty group accepted, next group accepted the following cycle
      clear_rec();
      send_group(0, 0, 0, 2'd0, 1'b1, 3);
      chk("t4_ready_again", 64'({in_ready, out_valid}), 64'b10);
      send_group(12, 0, 0, 2'd1, 1'b1, 4);
      chk("t4_next_valid", 64'(out_valid), 64'd1);
      wait_idle("t4");
      chk("t4_beats", 64'(beat_cnt), 64'd2);
      chk_eop("t4", 0, 2, 8'h0F, 32'd4);
      chk("t4_no_err", 64'(err), 64'd0);

      // 5: count mismatch
      clear_rec();
      send_group(35, 35, 0, 2'd3, 1'b0, 7);
      chk("t5_err_set", 64'(err), 64'd1);
      wait_idle("t5");
      chk("t5_beats", 64'(beat_cnt), 64'd10);
      chk("t5_msgs", 64'(eop_pos_q.size()), 64'd2);
      chk("t5_err_sticky", 64'(err), 64'd1);

      // oversize slot is clamped to 35 bytes
      clear_rec();
      send_group(40, 0, 0, 2'd1, 1'b0, 11);
      wait_idle("clamp");
      chk("clamp_beats", 64'(beat_cnt), 64'd5);
      chk_eop("clamp", 0, 5, 8'h07, 32'd0);

      // 6: reset, then counter wrap on the preset instance
      @(posedge clk); #3 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      model_seq = '0;
      seq2_q.delete();
      @(posedge clk); #1;
      chk("t6_err_cleared", 64'(err), 64'd0);
      clear_rec();
      send_group(12, 12, 0, 2'd2, 1'b1, 13);
      wait_idle("t6");
      chk_eop("t6m1", 0, 2, 8'h0F, 32'd0);
      chk_eop("t6m2", 1, 4, 8'h0F, 32'd1);
      chk("t6_wrap_count", 64'(seq2_q.size()), 64'd2);
      chk("t6_wrap_first", 64'(seq2_q[0]), 64'h0000_0000_FFFF_FFFF);
      chk("t6_wrap_second", 64'(seq2_q[1]), 64'd0);

      // reset asserted mid-message
      send_group(35, 22, 0, 2'd2, 1'b1, 17);
      @(posedge clk); #3;
      rst_n = 1'b0;
      exp_q.delete();
      model_seq = '0;
      #1;
      chk_reset_outputs("midreset");
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midreset_ready", 64'(in_ready), 64'd1);
      clear_rec();
      send_group(22, 0, 0, 2'd1, 1'b1, 19);
      wait_idle("post_reset");
      chk("post_reset_beats", 64'(beat_cnt), 64'd3);
      chk_eop("post_reset", 0, 3, 8'h3F, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
